branch_history_predictor: RTL

// - Fetch-side partner of the EX-stage branch comparator.
// - Predicts taken/not-taken for each fetched branch PC using a direct-mapped table of 2-bit saturating counters.
// - Trains each counter with the resolved outcome returned from EX.
// - Raises a one-cycle mispredict pulse for the front-end flush logic.
// - Keeps saturating statistics counters for branches resolved and branches mispredicted.

---
 rtl/bp_pkg.sv | 18 +
 rtl/bp_sat_counter2.sv | 23 ++
 rtl/branch_history_predictor.sv | 100 ++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor and its EX-stage partner.
// - BP_SNT/BP_WNT/BP_WT/BP_ST : 2-bit saturating counter states
// - EXE_B*_SEL                : branch-select codes shared with the ALU comparator
package bp_pkg;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  localparam logic [2:0] EXE_BEQ_SEL  = 3'd0;
  localparam logic [2:0] EXE_BNE_SEL  = 3'd1;
  localparam logic [2:0] EXE_BLT_SEL  = 3'd2;
  localparam logic [2:0] EXE_BGE_SEL  = 3'd3;
  localparam logic [2:0] EXE_BLTU_SEL = 3'd4;
  localparam logic [2:0] EXE_BGEU_SEL = 3'd5;

endpackage

// File: rtl/bp_sat_counter2.sv
// Combinational next-state function of a 2-bit saturating branch counter.
// Ports:
// - cur_i   : current counter state
// - taken_i : resolved branch outcome
// - nxt_o   : next counter state (saturates at BP_SNT and BP_ST)
module bp_sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cur_i,
  input  logic       taken_i,
  output logic [1:0] nxt_o
);

  always_comb begin
    nxt_o = cur_i;
    if (taken_i) begin
      if (cur_i != BP_ST) nxt_o = cur_i + 2'd1;
    end else begin
      if (cur_i != BP_SNT) nxt_o = cur_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_history_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with EX-side training,
// mispredict pulse and saturating statistics.
// Ports:
// - clk, rst_n                    : clock, asynchronous active-low reset
// - if_valid, if_pc               : fetch lookup request
// - pred_valid, pred_taken        : registered prediction, one cycle after lookup
// - ex_valid, ex_pc, ex_taken,
//   ex_pred_taken                 : resolved branch from EX
// - mispredict                    : registered one-cycle mispredict pulse
// - stat_branches, stat_mispred   : saturating resolved / mispredicted counts
module branch_history_predictor
  import bp_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic              ex_taken,
  input  logic              ex_pred_taken,
  output logic              mispredict,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int unsigned Depth = 2 ** IDX_W;

  // Flip-flop table: every entry must clear on reset, so no memory macro.
  logic [1:0]        table_q [Depth];
  logic [IDX_W-1:0]  if_idx, ex_idx;
  logic [1:0]        upd_nxt;
  logic [1:0]        lookup_ctr;
  logic              mispred_d;
  logic              pred_valid_q, pred_taken_q, mispredict_q;
  logic [STAT_W-1:0] stat_branches_q, stat_branches_d;
  logic [STAT_W-1:0] stat_mispred_q, stat_mispred_d;

  // Instructions are word aligned, so pc[1:0] carries no index information.
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  logic unused_pc;
  assign unused_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  bp_sat_counter2 u_upd_ctr (
    .cur_i   (table_q[ex_idx]),
    .taken_i (ex_taken),
    .nxt_o   (upd_nxt)
  );

  // Same-index update in the same cycle: forward the freshly trained value.
  always_comb begin
    lookup_ctr = table_q[if_idx];
    if (ex_valid && (ex_idx == if_idx)) lookup_ctr = upd_nxt;
  end

  always_comb begin
    mispred_d       = ex_valid & (ex_taken ^ ex_pred_taken);
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (ex_valid && (stat_branches_q != {STAT_W{1'b1}})) begin
      stat_branches_d = stat_branches_q + 1'b1;
    end
    if (mispred_d && (stat_mispred_q != {STAT_W{1'b1}})) begin
      stat_mispred_d = stat_mispred_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) table_q[i] <= BP_WNT;
      pred_valid_q    <= 1'b0;
      pred_taken_q    <= 1'b0;
      mispredict_q    <= 1'b0;
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      if (ex_valid) table_q[ex_idx] <= upd_nxt;
      pred_valid_q <= if_valid;
      if (if_valid) pred_taken_q <= lookup_ctr[1];
      mispredict_q    <= mispred_d;
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign pred_valid    = pred_valid_q;
  assign pred_taken    = pred_taken_q;
  assign mispredict    = mispredict_q;
  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;

endmodule
